// File: rtl/uart_pkg.sv
// Shared types and divisor arithmetic for the UART baud-rate generator.
package uart_pkg;

  localparam int DIV_W_DEF = 16;

  // What the prescaler does on a given edge, in priority order below reset.
  typedef enum logic [1:0] {
    STEP_COUNT,
    STEP_HOLD,
    STEP_SYNC
  } step_e;

  // Oversample divisor rounded to nearest: period = result + 1 clocks.
  function automatic longint calc_div(input longint clk_hz, input longint baud,
                                      input longint os);
    return (clk_hz + (baud * os) / 2) / (baud * os) - 1;
  endfunction

  localparam longint DIV_9600_12M   = calc_div(12000000, 9600, 16);
  localparam longint DIV_115200_12M = calc_div(12000000, 115200, 16);

endpackage

// File: rtl/uart_prescaler.sv
// Oversample prescaler: counts i_clk cycles against the active divisor and
// swaps in a pending divisor only where a bit period begins.
module uart_prescaler
  import uart_pkg::*;
#(
  parameter int               DIV_W       = DIV_W_DEF,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             en,
  input  logic             rx_sync,
  input  logic [DIV_W-1:0] div,
  input  logic             div_load,
  input  logic             bit_wrap,
  output logic             os_hit,
  output logic             os_tick,
  output logic [DIV_W-1:0] div_active,
  output logic             div_pending
);

  step_e            step;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_pend;
  logic [DIV_W-1:0] div_nxt;
  logic             apply;
  logic             apply_now;

  always_comb begin
    step = STEP_COUNT;
    if (rx_sync) begin
      step = STEP_SYNC;
    end else if (!en) begin
      step = STEP_HOLD;
    end
  end

  assign os_hit = (step == STEP_COUNT) && (cnt == div_active);

  // Swapping only at a bit boundary, sync or hold keeps every bit on one divisor.
  assign apply     = (step != STEP_COUNT) || (os_hit && bit_wrap);
  assign apply_now = apply && (div_pending || div_load);
  assign div_nxt   = div_load ? div : div_pend;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt         <= '0;
      div_active  <= DEFAULT_DIV;
      div_pend    <= DEFAULT_DIV;
      div_pending <= 1'b0;
      os_tick     <= 1'b0;
    end else begin
      os_tick <= os_hit;
      if (div_load) begin
        div_pend <= div;
      end
      if (apply_now) begin
        div_active  <= div_nxt;
        div_pending <= 1'b0;
      end else if (div_load) begin
        div_pending <= 1'b1;
      end
      if ((step == STEP_SYNC) || apply_now || os_hit) begin
        cnt <= '0;
      end else if (step == STEP_COUNT) begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable UART baud generator: oversample, bit and mid-bit enable ticks
// plus a 50% baud square wave, all in the i_clk domain.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = DIV_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_div_load,
  input  logic             i_rx_sync,
  output logic             o_os_tick,
  output logic             o_bit_tick,
  output logic             o_mid_tick,
  output logic             o_baud_clk,
  output logic [DIV_W-1:0] o_div_active,
  output logic             o_div_pending
);

  localparam longint           DEFAULT_DIV_L = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam logic [DIV_W-1:0] DEFAULT_DIV   = DIV_W'(DEFAULT_DIV_L);
  localparam int               PH_W          = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0]  PH_LAST       = PH_W'(OVERSAMPLE - 1);
  localparam logic [PH_W-1:0]  PH_MID        = PH_W'(OVERSAMPLE / 2);

  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
    $error("uart_baud_gen: OVERSAMPLE must be even and >= 4");
  end

  if ((DEFAULT_DIV_L < 0) || (DEFAULT_DIV_L >= (longint'(1) << DIV_W))) begin : g_bad_div
    $error("uart_baud_gen: default divisor does not fit in DIV_W bits");
  end

  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] ph_nxt;
  logic            bit_wrap;
  logic            os_hit;

  assign bit_wrap = (ph == PH_LAST);
  assign ph_nxt   = bit_wrap ? '0 : ph + PH_W'(1);

  uart_prescaler #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .en          (i_en),
    .rx_sync     (i_rx_sync),
    .div         (i_div),
    .div_load    (i_div_load),
    .bit_wrap    (bit_wrap),
    .os_hit      (os_hit),
    .os_tick     (o_os_tick),
    .div_active  (o_div_active),
    .div_pending (o_div_pending)
  );

  // Phase advances only on oversample hits; sync restarts the bit at phase 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ph         <= '0;
      o_bit_tick <= 1'b0;
      o_mid_tick <= 1'b0;
      o_baud_clk <= 1'b0;
    end else if (i_rx_sync) begin
      ph         <= '0;
      o_bit_tick <= 1'b0;
      o_mid_tick <= 1'b0;
      o_baud_clk <= 1'b1;
    end else if (os_hit) begin
      ph         <= ph_nxt;
      o_bit_tick <= bit_wrap;
      o_mid_tick <= (ph_nxt == PH_MID);
      o_baud_clk <= (ph_nxt < PH_MID);
    end else begin
      o_bit_tick <= 1'b0;
      o_mid_tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench for uart_baud_gen: directed scenarios push expected tick
// cycles into queues; a negedge monitor pops and compares each observed tick.
module tb_uart_baud_gen;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic [15:0] i_div;
  logic        i_div_load;
  logic        i_rx_sync;
  logic        o_os_tick;
  logic        o_bit_tick;
  logic        o_mid_tick;
  logic        o_baud_clk;
  logic [15:0] o_div_active;
  logic        o_div_pending;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;
  int win_lo  = 1;
  int win_hi  = 0;
  int q_os[$];
  int q_bit[$];
  int q_mid[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_baud_gen dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_en          (i_en),
    .i_div         (i_div),
    .i_div_load    (i_div_load),
    .i_rx_sync     (i_rx_sync),
    .o_os_tick     (o_os_tick),
    .o_bit_tick    (o_bit_tick),
    .o_mid_tick    (o_mid_tick),
    .o_baud_clk    (o_baud_clk),
    .o_div_active  (o_div_active),
    .o_div_pending (o_div_pending)
  );

  task automatic score(input string name, input int have_exp, input int exp_cyc);
    n_tests++;
    if (have_exp == 0) begin
      n_fail++;
      $display("FAIL %s: tick at cycle %0d, none expected", name, cyc);
    end else if (exp_cyc != cyc) begin
      n_fail++;
      $display("FAIL %s: tick at cycle %0d, expected cycle %0d", name, cyc, exp_cyc);
    end
  endtask

  always @(negedge clk) begin
    if ((cyc >= win_lo) && (cyc <= win_hi)) begin
      if (o_os_tick) begin
        if (q_os.size() > 0) score("os_tick", 1, q_os.pop_front());
        else                 score("os_tick", 0, 0);
      end
      if (o_bit_tick) begin
        if (q_bit.size() > 0) score("bit_tick", 1, q_bit.pop_front());
        else                  score("bit_tick", 0, 0);
      end
      if (o_mid_tick) begin
        if (q_mid.size() > 0) score("mid_tick", 1, q_mid.pop_front());
        else                  score("mid_tick", 0, 0);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    n_tests++;
    if ((q_os.size() + q_bit.size() + q_mid.size()) != 0) begin
      n_fail++;
      $display("FAIL %s: missing ticks os=%0d bit=%0d mid=%0d, expected 0 0 0",
               name, q_os.size(), q_bit.size(), q_mid.size());
    end
    q_os.delete();
    q_bit.delete();
    q_mid.delete();
    win_lo = 1;
    win_hi = 0;
  endtask

  task automatic run_to(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic close_window(input string name);
    run_to(win_hi);
    @(negedge clk);
    #1;
    drain(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, m, s, s2, l, b, h, s3, y, s4, d, p, t, r;
    i_rst = 1'b1; i_en = 1'b1; i_div = '0; i_div_load = 1'b0; i_rx_sync = 1'b0;

    // Reset state
    run_to(3);
    chk("rst_os", int'(o_os_tick), 0);
    chk("rst_bit", int'(o_bit_tick), 0);
    chk("rst_mid", int'(o_mid_tick), 0);
    chk("rst_baud", int'(o_baud_clk), 0);
    chk("rst_div_active", int'(o_div_active), 77);
    chk("rst_pending", int'(o_div_pending), 0);

    // Defaults after release: os every 78, bit every 1248, mid 624 after bit
    base = 5;
    for (int k = 1; k <= 32; k++) q_os.push_back(base + 78 * k);
    q_bit.push_back(base + 1248); q_bit.push_back(base + 2496);
    q_mid.push_back(base + 624);  q_mid.push_back(base + 1872);
    win_lo = base; win_hi = base + 2510;
    run_to(base); i_rst = 1'b0;
    run_to(base + 77);   chk("baud_before_first_os", int'(o_baud_clk), 0);
    run_to(base + 78);   chk("baud_rise", int'(o_baud_clk), 1);
    run_to(base + 623);  chk("baud_high_end", int'(o_baud_clk), 1);
    run_to(base + 624);  chk("baud_fall", int'(o_baud_clk), 0);
    run_to(base + 1247); chk("baud_low_end", int'(o_baud_clk), 0);
    run_to(base + 1248); chk("baud_rise2", int'(o_baud_clk), 1);
    chk("div_active_default", int'(o_div_active), 77);
    close_window("defaults");

    // Load div=0, applied by a later sync
    m = base + 2520;
    run_to(m - 1); i_div = 16'd0; i_div_load = 1'b1;
    run_to(m);     i_div_load = 1'b0;
    chk("div0_pending", int'(o_div_pending), 1);
    chk("div0_not_yet", int'(o_div_active), 77);
    s = m + 10;
    for (int k = 1; k <= 40; k++) q_os.push_back(s + k);
    q_bit.push_back(s + 16); q_bit.push_back(s + 32);
    q_mid.push_back(s + 8);  q_mid.push_back(s + 24); q_mid.push_back(s + 40);
    win_lo = s; win_hi = s + 40;
    run_to(s - 1); i_rx_sync = 1'b1;
    run_to(s);     i_rx_sync = 1'b0;
    chk("div0_applied", int'(o_div_active), 0);
    chk("div0_pending_clr", int'(o_div_pending), 0);
    chk("sync_baud_high", int'(o_baud_clk), 1);
    close_window("div0");

    // Sync with same-edge load of 77, then load 3 at ph=3
    s2 = s + 50;
    b  = s2 + 1248;
    for (int k = 1; k <= 16; k++) q_os.push_back(s2 + 78 * k);
    for (int j = 1; j <= 16; j++) q_os.push_back(b + 4 * j);
    q_bit.push_back(b); q_bit.push_back(b + 64);
    q_mid.push_back(s2 + 624); q_mid.push_back(b + 32);
    win_lo = s2; win_hi = b + 66;
    run_to(s2 - 1); i_rx_sync = 1'b1; i_div_load = 1'b1; i_div = 16'd77;
    run_to(s2);     i_rx_sync = 1'b0; i_div_load = 1'b0;
    chk("sync_load_same_edge", int'(o_div_active), 77);
    l = s2 + 240;
    run_to(l - 1); i_div = 16'd3; i_div_load = 1'b1;
    run_to(l);     i_div_load = 1'b0;
    chk("div3_pending", int'(o_div_pending), 1);
    run_to(b - 1);
    chk("div3_pending_hold", int'(o_div_pending), 1);
    chk("div3_old_active", int'(o_div_active), 77);
    run_to(b);
    chk("div3_applied_at_bit", int'(o_div_active), 3);
    chk("div3_pending_clr", int'(o_div_pending), 0);
    close_window("div3");

    // Load 77 while disabled (immediate), then sync at ph=5, cnt=40
    h  = b + 70;
    s3 = h + 1;
    y  = s3 + 430;
    for (int k = 1; k <= 5; k++)  q_os.push_back(s3 + 78 * k);
    for (int k = 1; k <= 16; k++) q_os.push_back(y + 78 * k);
    q_mid.push_back(y + 624);
    q_bit.push_back(y + 1248);
    win_lo = h; win_hi = y + 1250;
    run_to(h - 1); i_en = 1'b0; i_div = 16'd77; i_div_load = 1'b1;
    run_to(h);     i_en = 1'b1; i_div_load = 1'b0; i_rx_sync = 1'b1;
    chk("hold_apply", int'(o_div_active), 77);
    chk("hold_apply_pending", int'(o_div_pending), 0);
    run_to(s3);    i_rx_sync = 1'b0;
    run_to(y - 1); i_rx_sync = 1'b1;
    run_to(y);     i_rx_sync = 1'b0;
    chk("resync_os_zero", int'(o_os_tick), 0);
    chk("resync_baud", int'(o_baud_clk), 1);
    run_to(y + 624);
    chk("resync_baud_low_at_mid", int'(o_baud_clk), 0);
    close_window("resync");

    // Enable low for 500 cycles while baud is low
    s4 = y + 1260;
    d  = s4 + 700;
    for (int k = 1; k <= 8; k++)  q_os.push_back(s4 + 78 * k);
    for (int k = 9; k <= 16; k++) q_os.push_back(s4 + 78 * k + 500);
    q_mid.push_back(s4 + 624);
    q_bit.push_back(s4 + 1748);
    win_lo = s4; win_hi = s4 + 1750;
    run_to(s4 - 1); i_rx_sync = 1'b1;
    run_to(s4);     i_rx_sync = 1'b0;
    run_to(d - 1);  i_en = 1'b0;
    run_to(d);       chk("pause_baud_hold", int'(o_baud_clk), 0);
    run_to(d + 250); chk("pause_baud_hold_mid", int'(o_baud_clk), 0);
    run_to(d + 499); i_en = 1'b1;
    close_window("pause");

    // Asynchronous reset mid-bit discards a pending load
    p = s4 + 1760;
    t = s4 + 1826;
    run_to(p - 1); i_div = 16'd5; i_div_load = 1'b1;
    run_to(p);     i_div_load = 1'b0;
    chk("pre_rst_pending", int'(o_div_pending), 1);
    run_to(t);
    chk("pre_rst_os", int'(o_os_tick), 1);
    chk("pre_rst_baud", int'(o_baud_clk), 1);
    #2; i_rst = 1'b1;
    #1;
    chk("async_rst_os", int'(o_os_tick), 0);
    chk("async_rst_baud", int'(o_baud_clk), 0);
    chk("async_rst_div_active", int'(o_div_active), 77);
    chk("async_rst_pending", int'(o_div_pending), 0);
    r = t + 3;
    run_to(r); i_rst = 1'b0;
    q_os.push_back(r + 78); q_os.push_back(r + 156);
    win_lo = r; win_hi = r + 160;
    close_window("post_rst");
    chk("post_rst_div_active", int'(o_div_active), 77);
    chk("post_rst_pending", int'(o_div_pending), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
